// File: rtl/cmp_share_pkg.sv
// Shared types and helpers for the shared-comparator front end.
package cmp_share_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CMP  = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int NREQ_DEF  = 4;
  localparam int WIDTH_DEF = 4;
  localparam int NREQ_MAX  = 8;

  // First set bit of valid at or after ptr, wrapping modulo nreq; 0 if none set.
  function automatic logic [2:0] rr_pick(input logic [NREQ_MAX-1:0] valid,
                                         input int unsigned          nreq,
                                         input logic [2:0]           ptr);
    logic [2:0]  pick;
    logic        found;
    int unsigned idx;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < NREQ_MAX; k++) begin
      idx = (int'(ptr) + k) % nreq;
      if (!found && (k < nreq) && valid[idx[2:0]]) begin
        pick  = idx[2:0];
        found = 1'b1;
      end
    end
    return pick;
  endfunction

endpackage

// File: rtl/cmp_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: one-hot grant starting the search at ptr.
module rr_arbiter
  import cmp_share_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int IDW  = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] grant,
  output logic [IDW-1:0]  grant_id,
  output logic            any_req
);

  logic [NREQ_MAX-1:0] req_ext;
  logic [2:0]          ptr_ext;
  logic [2:0]          pick;

  always_comb begin
    req_ext             = '0;
    req_ext[NREQ-1:0]   = req;
    ptr_ext             = 3'(ptr);
    pick                = rr_pick(req_ext, NREQ, ptr_ext);
    grant_id            = pick[IDW-1:0];
    any_req             = |req;
    grant               = '0;
    if (any_req) grant[grant_id] = 1'b1;
  end

endmodule

// File: rtl/cmp_share_ctrl.sv
// Arbitrates NREQ requesters onto one unsigned magnitude comparator and returns tagged results.
module cmp_share_ctrl
  import cmp_share_pkg::*;
#(
  parameter int NREQ  = NREQ_DEF,
  parameter int WIDTH = WIDTH_DEF,
  parameter int IDW   = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req_valid,
  output logic [NREQ-1:0]       req_ready,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic [IDW-1:0]        rsp_id,
  output logic                  rsp_greater,
  output logic                  rsp_lesser,
  output logic                  rsp_equal,
  output logic                  busy
);

  state_e               state_q, state_d;
  logic [IDW-1:0]       rr_ptr_q, rr_ptr_d;
  logic [IDW-1:0]       id_q, id_d;
  logic                 gt_q, gt_d, lt_q, lt_d, eq_q, eq_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic                 busy_q, busy_d;
  logic [WIDTH-1:0]     op_a_q, op_a_d, op_b_q, op_b_d;

  logic [NREQ-1:0]      grant;
  logic [IDW-1:0]       grant_id;
  logic                 any_req;

  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req      (req_valid),
    .ptr      (rr_ptr_q),
    .grant    (grant),
    .grant_id (grant_id),
    .any_req  (any_req)
  );

  // Grants are only offered while idle so a request can never be accepted mid-transaction.
  assign req_ready   = (state_q == IDLE) ? grant : '0;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_id      = id_q;
  assign rsp_greater = gt_q;
  assign rsp_lesser  = lt_q;
  assign rsp_equal   = eq_q;
  assign busy        = busy_q;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    id_d        = id_q;
    gt_d        = gt_q;
    lt_d        = lt_q;
    eq_d        = eq_q;
    rsp_valid_d = rsp_valid_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    case (state_q)
      IDLE: begin
        if (any_req) begin
          op_a_d  = req_a[grant_id*WIDTH +: WIDTH];
          op_b_d  = req_b[grant_id*WIDTH +: WIDTH];
          id_d    = grant_id;
          state_d = CMP;
        end
      end
      CMP: begin
        gt_d        = (op_a_q > op_b_q);
        lt_d        = (op_a_q < op_b_q);
        eq_d        = (op_a_q == op_b_q);
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          rr_ptr_d    = (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      id_q        <= '0;
      gt_q        <= 1'b0;
      lt_q        <= 1'b0;
      eq_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      id_q        <= id_d;
      gt_q        <= gt_d;
      lt_q        <= lt_d;
      eq_q        <= eq_d;
      rsp_valid_q <= rsp_valid_d;
      busy_q      <= busy_d;
    end
  end

  // Operand registers are pure data and are always overwritten before use.
  always_ff @(posedge clk) begin
    op_a_q <= op_a_d;
    op_b_q <= op_b_d;
  end

endmodule
